// File: rtl/button_pkg.sv
// Shared encodings and default timing constants for the pushbutton debouncer.
package button_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      CHK_HI    = 2'b01,
      STABLE_HI = 2'b11,
      CHK_LO    = 2'b10
   } db_state_e;

   localparam int unsigned DEF_STABLE_CYCLES = 32'd1000000;
   localparam int unsigned DEF_LONG_CYCLES   = 32'd100000000;

   // High-side states are those in which the accepted level is 1.
   function automatic logic is_high_state(input db_state_e state);
      return (state == STABLE_HI) || (state == CHK_LO);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_r;
   logic q_r;

   // Shift the raw level through two flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d_i;
         q_r    <= meta_r;
      end
   end

   assign q_o = q_r;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer with optional long-press pulse.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to compile in the long-press hold counter.
module button_debounce
   import button_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_i,
   output logic button_o,
   output logic long_o
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 32'd1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

   if ((STABLE_CYCLES < 32'd1) || (STABLE_CYCLES > 32'd16777215) ||
       (LONG_CYCLES < 32'd1) || (LONG_CYCLES > 32'd268435455)) begin : g_bad_params
      $error("button_debounce: STABLE_CYCLES or LONG_CYCLES out of range");
   end

   logic            sync_q_s;
   db_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic            button_r;

   sync_2ff u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (button_i),
      .q_o   (sync_q_s)
   );

   // Debounce FSM: the counter only advances while a new level is being qualified.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= STABLE_LO;
         cnt_r    <= CNT_ZERO;
         button_r <= 1'b0;
      end else begin
         case (state_r)
            STABLE_LO: begin
               cnt_r    <= CNT_ZERO;
               button_r <= 1'b0;
               if (sync_q_s) state_r <= CHK_HI;
               else          state_r <= STABLE_LO;
            end
            CHK_HI: begin
               if (!sync_q_s) begin
                  state_r <= STABLE_LO;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r  <= STABLE_HI;
                  cnt_r    <= CNT_ZERO;
                  button_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STABLE_HI: begin
               cnt_r    <= CNT_ZERO;
               button_r <= 1'b1;
               if (!sync_q_s) state_r <= CHK_LO;
               else           state_r <= STABLE_HI;
            end
            CHK_LO: begin
               if (sync_q_s) begin
                  state_r <= STABLE_HI;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r  <= STABLE_LO;
                  cnt_r    <= CNT_ZERO;
                  button_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r  <= STABLE_LO;
               cnt_r    <= CNT_ZERO;
               button_r <= 1'b0;
            end
         endcase
      end
   end

   assign button_o = button_r;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
   localparam int HOLD_W = $clog2(LONG_CYCLES + 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

   logic [HOLD_W-1:0] hold_r;
   logic              long_r;

   // Hold counter parks at LONG_CYCLES after firing, so one pulse per press.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_r <= '0;
         long_r <= 1'b0;
      end else if (is_high_state(state_r)) begin
         long_r <= (hold_r == HOLD_LAST);
         if (hold_r != HOLD_SAT) hold_r <= hold_r + HOLD_ONE;
         else                    hold_r <= hold_r;
      end else begin
         hold_r <= '0;
         long_r <= 1'b0;
      end
   end

   assign long_o = long_r;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboarded bench for button_debounce with STABLE_CYCLES=4, LONG_CYCLES=10.
module tb_button_debounce;

   localparam int S = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst_s = 1'b1;
   logic btn_s = 1'b0;
   logic button_o_s;
   logic long_o_s;

   int errors = 0;
   int checks = 0;
   logic [1:0]  exp_q[$];
   logic [63:0] raw_hist = '0;
   logic [63:0] deb_hist = '0;
   int cyc, rise_at, long_at, long_cnt;
   bit drop_seen;

   button_debounce #(.STABLE_CYCLES(S), .LONG_CYCLES(L)) dut (
      .clk_i    (clk),
      .rst_i    (rst_s),
      .button_i (btn_s),
      .button_o (button_o_s),
      .long_o   (long_o_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Behavioural model: a level is accepted once S+1 consecutive samples show it,
   // two edges later (synchronizer delay); long fires L edges after a sustained rise.
   function automatic void model_edge(input logic r, input logic rs);
      logic prev, nd, lg;
      logic [S:0] win;
      if (rs) begin
         raw_hist = '0;
         deb_hist = '0;
         exp_q.push_back(2'b00);
      end else begin
         raw_hist = {raw_hist[62:0], r};
         prev = deb_hist[0];
         win = raw_hist[S+2:2];
         nd = prev;
         if (win == {(S+1){~prev}}) nd = ~prev;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
         lg = (deb_hist[L-1:0] == {L{1'b1}}) && !deb_hist[L];
`else
         lg = 1'b0;
`endif
         deb_hist = {deb_hist[62:0], nd};
         exp_q.push_back({nd, lg});
      end
   endfunction

   task automatic step(input logic r, input logic rs);
      logic [1:0] e;
      @(negedge clk);
      btn_s = r;
      rst_s = rs;
      @(posedge clk);
      model_edge(r, rs);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("button_o", 32'(button_o_s), 32'(e[1]));
         check("long_o", 32'(long_o_s), 32'(e[0]));
      end
      if (button_o_s && rise_at < 0) rise_at = cyc;
      if (!button_o_s && rise_at >= 0) drop_seen = 1'b1;
      if (long_o_s) begin
         long_cnt++;
         if (long_at < 0) long_at = cyc;
      end
      cyc++;
   endtask

   task automatic reset_and_start();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cyc = 0;
      rise_at = -1;
      long_at = -1;
      long_cnt = 0;
      drop_seen = 1'b0;
   endtask

   task automatic hold(input logic r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0);
   endtask

   initial begin
      int lvl, len;
      cyc = 0;
      // Reset state
      reset_and_start();
      check("reset_button", 32'(button_o_s), 32'd0);
      check("reset_long", 32'(long_o_s), 32'd0);

      // Clean rise at cycle 0: accepted at cycle 6
      hold(1'b1, 12);
      check("rise_clean", 32'(rise_at), 32'd6);
      hold(1'b0, 10);

      // Bouncy press 1,1,1,0 then high: 6 cycles after the last rising edge (cycle 4)
      reset_and_start();
      hold(1'b1, 3);
      hold(1'b0, 1);
      hold(1'b1, 12);
      check("rise_bounce", 32'(rise_at), 32'd10);

      // Two-cycle low glitch while high must not drop button_o
      reset_and_start();
      hold(1'b1, 10);
      hold(1'b0, 2);
      hold(1'b1, 10);
      check("glitch_rise", 32'(rise_at), 32'd6);
      check("glitch_no_drop", 32'(drop_seen), 32'd0);

      // Reset mid-count abandons progress
      reset_and_start();
      hold(1'b1, 3);
      step(1'b1, 1'b1);
      hold(1'b1, 10);
      check("rise_after_rst", 32'(rise_at), 32'd10);

      // Long press then a fresh 16-cycle press
      reset_and_start();
      hold(1'b1, 30);
      hold(1'b0, 12);
      hold(1'b1, 16);
      hold(1'b0, 12);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
      check("long_first_at", 32'(long_at), 32'(rise_at + L));
      check("long_count", 32'(long_cnt), 32'd2);
`else
      check("long_count", 32'(long_cnt), 32'd0);
`endif

      // Random bounce runs with occasional resets
      reset_and_start();
      for (int k = 0; k < 120; k++) begin
         lvl = $urandom_range(1, 0);
         len = $urandom_range(8, 1);
         if ($urandom_range(29, 0) == 0) step(1'(lvl), 1'b1);
         hold(1'(lvl), len);
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1000000, giving the consecutive synchronized cycles a new input level must hold before being accepted (legal range 1..2^24-1).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100000000, giving the debounced-high duration that flags a long press (legal range 1..2^28-1).
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port button_i, input, 1 bit: raw asynchronous pushbutton level.
REQ-006 The block SHALL have port button_o, output, 1 bit: debounced level, registered, driving the button event FSM input.
REQ-007 The block SHALL have port long_o, output, 1 bit: one-cycle long-press pulse, registered.

Function
REQ-008 The block SHALL pass button_i through a two-flop synchronizer; sync_q is the second flop's output.
REQ-009 The state machine SHALL have four states: STABLE_LO, CHK_HI, STABLE_HI and CHK_LO.
REQ-010 In STABLE_LO, sync_q=1 SHALL go to CHK_HI with the counter cleared to 0; otherwise the state SHALL hold.
REQ-011 In CHK_HI, sync_q=0 SHALL return to STABLE_LO with the counter cleared, and sync_q=1 SHALL increment the counter.
REQ-012 In CHK_HI, when sync_q=1 and the counter equals STABLE_CYCLES-1, the block SHALL go to STABLE_HI and set button_o=1 on the same edge.
REQ-013 STABLE_HI and CHK_LO SHALL be symmetric to REQ-010..012 with levels inverted; entering STABLE_LO from CHK_LO SHALL clear button_o.
REQ-014 For an input held clean, button_o SHALL change exactly STABLE_CYCLES+2 clocks after the first edge that samples the new raw level into the first sync flop.
REQ-015 Any glitch shorter than STABLE_CYCLES synchronized cycles SHALL leave button_o unchanged and SHALL restart the count from 0.
REQ-016 The debounce counter SHALL be exactly $clog2(STABLE_CYCLES+1) bits wide, SHALL never wrap, and SHALL only count in CHK_HI or CHK_LO.
REQ-017 If STABLE_CYCLES=1, a CHK state SHALL be held for exactly one cycle before acceptance.
REQ-018 Only the state encoded in the state register SHALL determine button_o; unreachable encodings SHALL go to STABLE_LO with button_o=0.

Reset
REQ-019 While rst_i=1 at a clock edge, both sync flops, the state (STABLE_LO), all counters, button_o and long_o SHALL be cleared to 0.
REQ-020 Reset asserted mid-count SHALL abandon the count; after release the block SHALL need the full STABLE_CYCLES again.
REQ-021 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-022 Macro BUTTON_DEBOUNCE_LONGPRESS_EN SHALL compile in the long-press feature.
REQ-023 With the macro defined, a hold counter of $clog2(LONG_CYCLES+1) bits SHALL count cycles in STABLE_HI and CHK_LO.
REQ-024 With the macro defined, long_o SHALL pulse for one cycle when the hold count reaches LONG_CYCLES-1, at most once per press.
REQ-025 With the macro defined, the hold counter SHALL clear and re-arm on entering STABLE_LO and SHALL saturate rather than wrap.
REQ-026 Without the macro, the hold counter SHALL be absent, the long_o port SHALL remain, and long_o SHALL be tied to constant 0.

Structure
REQ-027 The state encodings (STABLE_LO=2'b00, CHK_HI=2'b01, STABLE_HI=2'b11, CHK_LO=2'b10) and the default cycle constants SHALL live in the shared package button_pkg.
REQ-028 The two-flop synchronizer SHALL be the sub-module sync_2ff with ports clk_i, rst_i, d_i and q_o, reset value 0.

Verification (STABLE_CYCLES=4, LONG_CYCLES=10)
REQ-029 The bench SHALL raise button_i clean at cycle 0 and hold it; button_o SHALL rise at cycle 6 and no earlier.
REQ-030 The bench SHALL drive button_i as 1,1,1,0,1,1,1,1,1…; button_o SHALL rise 6 cycles after the final rising edge, with no early assertion.
REQ-031 The bench SHALL drop button_i after button_o=1 with a 2-cycle low glitch, then hold it high; button_o SHALL stay 1 throughout.
REQ-032 The bench SHALL assert rst_i for 1 cycle after 3 cycles of a high hold; button_o SHALL stay 0 and then SHALL rise 6 cycles after rst_i deasserts with button_i still high.
REQ-033 With BUTTON_DEBOUNCE_LONGPRESS_EN defined, the bench SHALL hold button_i high for 30 cycles; long_o SHALL pulse exactly once, 10 cycles after button_o rises, and SHALL re-pulse only after a release followed by a new 16-cycle press.
REQ-034 Without BUTTON_DEBOUNCE_LONGPRESS_EN, the bench SHALL repeat the REQ-033 stimulus; long_o SHALL stay 0 throughout.
